// File: rtl/ram_port_arbiter_if.sv
// Requester handshake and RAM control pins shared by the arbiter and its masters.
// The bidirectional RAM data bus stays a plain inout port on the arbiter.
interface ram_port_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);
  logic                  req_valid_0;
  logic                  req_valid_1;
  logic                  req_we_0;
  logic                  req_we_1;
  logic [ADDR_WIDTH-1:0] req_addr_0;
  logic [ADDR_WIDTH-1:0] req_addr_1;
  logic [DATA_WIDTH-1:0] req_wdata_0;
  logic [DATA_WIDTH-1:0] req_wdata_1;
  logic                  req_ready_0;
  logic                  req_ready_1;
  logic                  rsp_valid_0;
  logic                  rsp_valid_1;
  logic [DATA_WIDTH-1:0] rsp_rdata_0;
  logic [DATA_WIDTH-1:0] rsp_rdata_1;
  logic                  ram_cs;
  logic                  ram_we;
  logic                  ram_oe;
  logic [ADDR_WIDTH-1:0] ram_addr;

  modport slave (
    input  req_valid_0, req_valid_1, req_we_0, req_we_1,
    input  req_addr_0, req_addr_1, req_wdata_0, req_wdata_1,
    output req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1,
    output rsp_rdata_0, rsp_rdata_1,
    output ram_cs, ram_we, ram_oe, ram_addr
  );

  modport master (
    output req_valid_0, req_valid_1, req_we_0, req_we_1,
    output req_addr_0, req_addr_1, req_wdata_0, req_wdata_1,
    input  req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1,
    input  rsp_rdata_0, rsp_rdata_1,
    input  ram_cs, ram_we, ram_oe, ram_addr
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin two-requester controller for a single-port synchronous RAM;
// sequences cs/we/oe/addr, drives the data bus only while writing.
module ram_port_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ram_port_arbiter_if.slave     bus,
  inout  wire  [DATA_WIDTH-1:0] ram_data
);

  typedef enum logic [1:0] {IDLE, WR, RD1, RD2} state_t;

  state_t                state;
  state_t                state_next;
  logic                  last_grant;
  logic                  gnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  win0;
  logic                  win1;
  logic                  accept;

  always_comb begin
    state_next      = state;
    win0            = 1'b0;
    win1            = 1'b0;
    accept          = 1'b0;
    bus.req_ready_0 = 1'b0;
    bus.req_ready_1 = 1'b0;
    case (state)
      IDLE: begin
        // On a tie the requester not granted last wins.
        win1            = bus.req_valid_1 && (!bus.req_valid_0 || !last_grant);
        win0            = bus.req_valid_0 && !win1;
        accept          = win0 || win1;
        bus.req_ready_0 = win0;
        bus.req_ready_1 = win1;
        if (win1)      state_next = bus.req_we_1 ? WR : RD1;
        else if (win0) state_next = bus.req_we_0 ? WR : RD1;
      end
      WR:      state_next = IDLE;
      RD1:     state_next = RD2;
      RD2:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // RAM pins depend on the state register only.
  assign bus.ram_cs   = (state != IDLE);
  assign bus.ram_we   = (state == WR);
  assign bus.ram_oe   = (state != WR);
  assign bus.ram_addr = addr_q;
  assign ram_data     = (state == WR) ? wdata_q : {DATA_WIDTH{1'bz}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      last_grant      <= 1'b1;
      gnt_q           <= 1'b0;
      addr_q          <= '0;
      bus.rsp_valid_0 <= 1'b0;
      bus.rsp_valid_1 <= 1'b0;
      bus.rsp_rdata_0 <= '0;
      bus.rsp_rdata_1 <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        last_grant <= win1;
        gnt_q      <= win1;
        addr_q     <= win1 ? bus.req_addr_1 : bus.req_addr_0;
      end
      bus.rsp_valid_0 <= (state == RD2) && !gnt_q;
      bus.rsp_valid_1 <= (state == RD2) &&  gnt_q;
      if ((state == RD2) && !gnt_q) bus.rsp_rdata_0 <= ram_data;
      if ((state == RD2) &&  gnt_q) bus.rsp_rdata_1 <= ram_data;
    end
  end

  // Write data is only meaningful once a write has been accepted.
  always_ff @(posedge clk) begin
    if (accept) wdata_q <= win1 ? bus.req_wdata_1 : bus.req_wdata_0;
  end

endmodule
